// File: rtl/s4ga_cfg_stream.sv
// ---------------------------------------------------------------------------
// s4ga_cfg_stream
//
// Configuration replay stage for the s4ga LUT-evaluation core. A complete
// LUT-config bitstream (DEPTH = N*LL segments of SI_W bits) is captured over a
// valid-qualified load port into an internal segment memory. Once the last
// segment is stored, the core is held in reset for RST_CYC cycles. The stored
// stream is then replayed on si, one segment per clock, wrapping endlessly.
// Because this block also drives the core reset, segment 0 always lands on
// the core's first post-reset cycle.
//
// Ports
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   ld_start  in   one-cycle pulse: abort everything, begin a new load
//   ld_valid  in   ld_data carries a segment this cycle
//   ld_data   in   [SI_W] segment to store, in stream order
//   core_rst  out  registered reset to the core (1 out of reset)
//   si        out  [SI_W] registered segment stream to the core
//   sof       out  registered, 1 exactly when si carries segment 0
//   running   out  registered, 1 while replaying
//   ld_err    out  sticky: ld_valid seen outside a load
// ---------------------------------------------------------------------------
module s4ga_cfg_stream #(
  parameter int N       = 89,
  parameter int LL      = 18,
  parameter int SI_W    = 4,
  parameter int RST_CYC = N + 1   // must exceed N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_start,
  input  logic            ld_valid,
  input  logic [SI_W-1:0] ld_data,
  output logic            core_rst,
  output logic [SI_W-1:0] si,
  output logic            sof,
  output logic            running,
  output logic            ld_err
);

  localparam int DEPTH = N * LL;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RC_W  = $clog2(RST_CYC + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [RC_W-1:0]  LAST_HOLD = RC_W'(RST_CYC - 1);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [RC_W-1:0]  r_hold_cnt;
  logic             r_core_rst;
  logic [SI_W-1:0]  r_si;
  logic             r_sof;
  logic             r_running;
  logic             r_ld_err;
  logic [SI_W-1:0]  r_mem [DEPTH];

  logic             w_wr_en;
  logic             w_wr_last;
  logic             w_hold_done;
  logic             w_rd_last;
  logic [SI_W-1:0]  w_rd_data;

  // A start pulse (or reset) in the same cycle as ld_valid drops the data.
  assign w_wr_en     = ld_valid && !ld_start && !rst && (r_state == S_LOAD);
  assign w_wr_last   = (r_wr_ptr == LAST_PTR);
  assign w_hold_done = (r_hold_cnt == LAST_HOLD);
  assign w_rd_last   = (r_rd_ptr == LAST_PTR);
  assign w_rd_data   = r_mem[r_rd_ptr];

  // NOTE: the segment memory has no reset; it is only read after a full load
  // has overwritten every entry, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= ld_data;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // sees pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_hold_cnt <= '0;
      r_core_rst <= 1'b1;
      r_si       <= '0;
      r_sof      <= 1'b0;
      r_running  <= 1'b0;
      r_ld_err   <= 1'b0;
    end else if (ld_start) begin
      // Abort from any state; the core is back in reset on this same edge.
      r_state    <= S_LOAD;
      r_wr_ptr   <= '0;
      r_hold_cnt <= '0;
      r_core_rst <= 1'b1;
      r_si       <= '0;
      r_sof      <= 1'b0;
      r_running  <= 1'b0;
      r_ld_err   <= 1'b0;
    end else begin
      // Outputs idle unless RUN overrides them below.
      r_core_rst <= 1'b1;
      r_si       <= '0;
      r_sof      <= 1'b0;
      r_running  <= 1'b0;

      if (ld_valid && (r_state != S_LOAD)) begin
        r_ld_err <= 1'b1;
      end

      case (r_state)
        S_EMPTY: begin
          // Waiting for a load; nothing to do.
        end

        S_LOAD: begin
          if (ld_valid) begin
            if (w_wr_last) begin
              r_wr_ptr   <= '0;
              r_state    <= S_HOLD;
              r_hold_cnt <= '0;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end

        S_HOLD: begin
          // Counter runs 0..RST_CYC-1, so HOLD spans exactly RST_CYC edges;
          // the edge entering RUN is the last one presenting core_rst=1.
          r_hold_cnt <= r_hold_cnt + 1'b1;
          if (w_hold_done) begin
            r_state  <= S_RUN;
            r_rd_ptr <= '0;
          end
        end

        S_RUN: begin
          r_core_rst <= 1'b0;
          r_si       <= w_rd_data;
          r_sof      <= (r_rd_ptr == '0);
          r_running  <= 1'b1;
          r_rd_ptr   <= w_rd_last ? '0 : r_rd_ptr + 1'b1;
        end

        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  assign core_rst = r_core_rst;
  assign si       = r_si;
  assign sof      = r_sof;
  assign running  = r_running;
  assign ld_err   = r_ld_err;

endmodule

// File: doc/s4ga_cfg_stream.md
# s4ga_cfg_stream

Configuration replay stage sitting directly upstream of the s4ga LUT-evaluation core. It accepts one complete LUT-config bitstream of N*LL segments (SI_W bits each) over a simple valid-qualified load port and stores it in an internal segment memory. It then holds the core in reset for RST_CYC cycles and replays the stored stream on `si`, one segment per clock, wrapping endlessly. It also drives the core's `rst`, so segment 0 always lands on the core's first post-reset cycle.

## Interface
- `N`, 89: number of LUTs in the downstream core.
- `LL`, 18: segments per LUT config (K*IDX_SEGS + MASK_SEGS of the core).
- `SI_W`, 4: segment width.
- `RST_CYC`, N+1: core reset hold length in cycles; must be > N.
- Derived: DEPTH = N*LL; PTR_W = $clog2(DEPTH); RC_W = $clog2(RST_CYC+1).
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `ld_start`  in  1  one-cycle pulse; aborts any activity and begins a new load at segment 0.
- `ld_valid`  in  1  `ld_data` holds a segment this cycle.
- `ld_data`  in  SI_W  segment to store, in stream order.
- `core_rst`  out  1  registered reset to the core; reset value 1.
- `si`  out  SI_W  registered segment stream to the core; reset value 0.
- `sof`  out  1  registered; 1 exactly when `si` carries segment 0; reset value 0.
- `running`  out  1  registered; 1 in RUN; reset value 0.
- `ld_err`  out  1  sticky; `ld_valid` received outside LOAD; reset value 0; cleared by `rst` or `ld_start`.

## Operation
- State machine states are EMPTY, LOAD, HOLD and RUN.
- `rst` forces state EMPTY, wr_ptr=0, rd_ptr=0, hold counter=0, and all outputs to their reset values. Memory contents are not cleared.
- EMPTY: `core_rst`=1, `si`=0. `ld_start` goes to LOAD. `ld_valid` sets `ld_err` and is otherwise ignored.
- LOAD: `core_rst`=1, `si`=0.
  - Each `ld_valid` writes mem[wr_ptr]=`ld_data` and increments wr_ptr.
  - The write at wr_ptr==DEPTH-1 goes to HOLD with hold counter=0.
  - Cycles without `ld_valid` leave all state unchanged; gaps have unlimited length.
- HOLD: `core_rst`=1, `si`=0. The hold counter increments each cycle. When the counter reaches RST_CYC-1, go to RUN with rd_ptr=0. HOLD therefore lasts exactly RST_CYC cycles.
- RUN: each cycle `si`<=mem[rd_ptr], `sof`<=(rd_ptr==0), `core_rst`<=0, `running`<=1.
  - rd_ptr increments and wraps from DEPTH-1 to 0.
  - `ld_valid` sets `ld_err` and does not write.
- `ld_start` in any state, including mid-LOAD, HOLD and RUN:
  - go to LOAD with wr_ptr=0 and clear `ld_err`;
  - on the next output edge, `core_rst`=1, `si`=0, `sof`=0 and `running`=0.
- `ld_start` and `ld_valid` in the same cycle: start wins and the data is dropped. The first stored segment is the next `ld_valid`.
- `rst` and `ld_start` in the same cycle: `rst` wins and the state is EMPTY.
- Memory is a single array of DEPTH x SI_W, written in LOAD and read in RUN only. It has no concurrent read/write hazard.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Memory read is combinational into the `si` register (read and register in one cycle).
- The output edge on which state becomes RUN presents `core_rst`=1 for its last time. The next edge presents `core_rst`=0, `si`=mem[0], `sof`=1 and `running`=1.
- The core samples `rst` and `si` through its own input register, so both arrive aligned and segment 0 is consumed on the core's first non-reset cycle.
- Stream period is exactly DEPTH cycles. `sof` pulses every DEPTH cycles with no bubbles.
- Latency from the last load write to the first `core_rst`=0 output is RST_CYC+1 cycles.
- `core_rst` is high continuously for at least RST_CYC cycles before every RUN entry.

## Test plan
Use N=3, LL=2, SI_W=4, RST_CYC=4, DEPTH=6 unless noted.
1. Reset, then `ld_start`, then load A,B,C,D,E,F back-to-back:
   - `core_rst`=1 through the 4 HOLD cycles;
   - then `si`=A,B,C,D,E,F,A,B… with `sof`=1 on each A;
   - `running`=1 from the first A.
2. Load with random gaps of 0–5 idle cycles between `ld_valid` pulses -> identical output stream to scenario 1; no `ld_err`.
3. `ld_valid` with 0x7 while in RUN:
   - `ld_err`=1 on the next edge;
   - the stream remains A..F unchanged;
   - a subsequent `ld_start` clears `ld_err`.
4. `ld_start` mid-RUN (while `si`=C), then load 1..6:
   - next edge `core_rst`=1, `si`=0;
   - after load plus 4 HOLD cycles, `si`=1,2,3,4,5,6,1…
5. `ld_start` after 3 segments, then 6 fresh segments 9..E -> stream 9,A,B,C,D,E; no stale data is replayed.
6. `rst` asserted mid-HOLD and mid-RUN -> next edge all outputs at reset values and state EMPTY. `ld_start` together with `ld_valid` -> that segment is not stored.
